exe_issue_scheduler: RTL and testbench

- Reservation station and oldest-first issue scheduler for the single EXE unit.
- Dispatch writes renamed instructions in with their ROB entry. Unresolved sources wait on result broadcasts matched by ROB tag.
- Each cycle the oldest entry with both operands ready drives EXE's instruction inputs. It is retired from the station when EXE's Want_Instr accepts it.
- Sits between rename/ROB allocation and EXE.

---
 rtl/exe_issue_scheduler_pkg.sv | 26 ++
 rtl/exe_issue_scheduler_if.sv | 51 +++++
 rtl/exe_age_select.sv | 21 ++
 rtl/exe_issue_scheduler.sv | 177 +++++++++++++++++
 tb/tb_exe_issue_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_issue_scheduler_pkg.sv
// Shared definitions for the EXE reservation station: widths, operand indexing and the
// field layout of the opaque payload bundle carried from rename to EXE.
package exe_issue_scheduler_pkg;

  localparam int unsigned TagW     = 6;
  localparam int unsigned DataW    = 32;
  localparam int unsigned PayloadW = 128;
  localparam int unsigned NumSrc   = 2;

  // Payload bundle layout (LSB offsets); the station never looks inside it.
  localparam int unsigned PlInstrLsb   = 0;
  localparam int unsigned PlPcLsb      = 32;
  localparam int unsigned PlImmLsb     = 64;
  localparam int unsigned PlAluCtrlLsb = 96;
  localparam int unsigned PlShamtLsb   = 102;
  localparam int unsigned PlWrRegLsb   = 107;
  localparam int unsigned PlMemCtrlLsb = 112;

  typedef logic [DataW-1:0] data_t;

  typedef enum logic {
    SrcA = 1'b0,
    SrcB = 1'b1
  } src_e;

endpackage

// File: rtl/exe_issue_scheduler_if.sv
// Dispatch, result-broadcast and issue signals between rename/ROB, the station and EXE.
interface exe_issue_scheduler_if
  import exe_issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TAG_W     = TagW,
  parameter int unsigned PAYLOAD_W = PayloadW
) ();
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                 Flush_IN;
  logic                 Disp_Valid_IN;
  logic                 Disp_Ready_OUT;
  logic [TAG_W-1:0]     Disp_ROB_entry_IN;
  logic [PAYLOAD_W-1:0] Disp_Payload_IN;
  logic                 Disp_SrcA_Ready_IN;
  logic [TAG_W-1:0]     Disp_SrcA_Tag_IN;
  logic [DataW-1:0]     Disp_SrcA_Data_IN;
  logic                 Disp_SrcB_Ready_IN;
  logic [TAG_W-1:0]     Disp_SrcB_Tag_IN;
  logic [DataW-1:0]     Disp_SrcB_Data_IN;
  logic                 CDB_Valid_IN;
  logic [TAG_W-1:0]     CDB_ROB_entry_IN;
  logic [DataW-1:0]     CDB_Data_IN;
  logic                 EXE_Want_Instr_IN;
  logic                 Issue_Valid_OUT;
  logic [TAG_W-1:0]     Issue_ROB_entry_OUT;
  logic [DataW-1:0]     Issue_OperandA_OUT;
  logic [DataW-1:0]     Issue_OperandB_OUT;
  logic [PAYLOAD_W-1:0] Issue_Payload_OUT;
  logic [CntW-1:0]      Count_OUT;

  modport master (
    output Flush_IN, Disp_Valid_IN, Disp_ROB_entry_IN, Disp_Payload_IN,
           Disp_SrcA_Ready_IN, Disp_SrcA_Tag_IN, Disp_SrcA_Data_IN,
           Disp_SrcB_Ready_IN, Disp_SrcB_Tag_IN, Disp_SrcB_Data_IN,
           CDB_Valid_IN, CDB_ROB_entry_IN, CDB_Data_IN, EXE_Want_Instr_IN,
    input  Disp_Ready_OUT, Issue_Valid_OUT, Issue_ROB_entry_OUT, Issue_OperandA_OUT,
           Issue_OperandB_OUT, Issue_Payload_OUT, Count_OUT
  );

  modport slave (
    input  Flush_IN, Disp_Valid_IN, Disp_ROB_entry_IN, Disp_Payload_IN,
           Disp_SrcA_Ready_IN, Disp_SrcA_Tag_IN, Disp_SrcA_Data_IN,
           Disp_SrcB_Ready_IN, Disp_SrcB_Tag_IN, Disp_SrcB_Data_IN,
           CDB_Valid_IN, CDB_ROB_entry_IN, CDB_Data_IN, EXE_Want_Instr_IN,
    output Disp_Ready_OUT, Issue_Valid_OUT, Issue_ROB_entry_OUT, Issue_OperandA_OUT,
           Issue_OperandB_OUT, Issue_Payload_OUT, Count_OUT
  );

endinterface

// File: rtl/exe_age_select.sv
// Oldest-first picker: age_i[i][j] set means entry j is older than entry i. Grants the one
// requester with no older requester.
module exe_age_select #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] age_i [N],
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o,
  output logic         any_o
);

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = req_i[i] & ~(|(age_i[i] & req_i));
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/exe_issue_scheduler.sv
// Reservation station for the single EXE unit: captures dispatched instructions, wakes
// sources on CDB tag match and presents the oldest fully-ready entry to EXE.
module exe_issue_scheduler
  import exe_issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TAG_W     = TagW,
  parameter int unsigned PAYLOAD_W = PayloadW
) (
  input logic               CLK,
  input logic               RESET,
  exe_issue_scheduler_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [NumSrc-1:0]    rdy_q     [DEPTH];
  logic [NumSrc-1:0]    rdy_d     [DEPTH];
  logic [TAG_W-1:0]     tag_q     [DEPTH][NumSrc];
  logic [TAG_W-1:0]     tag_d     [DEPTH][NumSrc];
  data_t                data_q    [DEPTH][NumSrc];
  data_t                data_d    [DEPTH][NumSrc];
  logic [TAG_W-1:0]     rob_q     [DEPTH];
  logic [TAG_W-1:0]     rob_d     [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_d [DEPTH];
  logic [DEPTH-1:0]     age_q     [DEPTH];
  logic [DEPTH-1:0]     age_d     [DEPTH];
  logic [CntW-1:0]      count_q, count_d;

  logic [NumSrc-1:0] raw_rdy, in_rdy;
  logic [TAG_W-1:0]  in_tag  [NumSrc];
  data_t             raw_data[NumSrc];
  data_t             in_data [NumSrc];
  logic [DEPTH-1:0]  req, grant;
  logic              grant_any;
  logic [IdxW-1:0]   free_idx;
  logic              disp_ready, accept, issue;

  // Incoming sources, with a same-cycle broadcast bypass for not-ready ones.
  always_comb begin
    raw_rdy[SrcA]  = bus.Disp_SrcA_Ready_IN;
    raw_rdy[SrcB]  = bus.Disp_SrcB_Ready_IN;
    in_tag[SrcA]   = bus.Disp_SrcA_Tag_IN;
    in_tag[SrcB]   = bus.Disp_SrcB_Tag_IN;
    raw_data[SrcA] = bus.Disp_SrcA_Data_IN;
    raw_data[SrcB] = bus.Disp_SrcB_Data_IN;
    in_rdy         = raw_rdy;
    for (int s = 0; s < NumSrc; s++) begin
      in_data[s] = raw_data[s];
      if (!raw_rdy[s] && bus.CDB_Valid_IN && (in_tag[s] == bus.CDB_ROB_entry_IN)) begin
        in_rdy[s]  = 1'b1;
        in_data[s] = bus.CDB_Data_IN;
      end
    end
  end

  always_comb begin
    req = '0;
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = valid_q[i] & (&rdy_q[i]);
    end
  end

  exe_age_select #(
    .N(DEPTH)
  ) u_age_select (
    .age_i  (age_q),
    .req_i  (req),
    .grant_o(grant),
    .any_o  (grant_any)
  );

  // Descending scan so the lowest free index wins.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IdxW'(i);
    end
  end

  assign disp_ready = (count_q < CntW'(DEPTH));
  assign accept     = bus.Disp_Valid_IN & disp_ready & ~bus.Flush_IN;
  assign issue      = grant_any & bus.EXE_Want_Instr_IN & ~bus.Flush_IN;

  always_comb begin
    valid_d   = valid_q;
    rdy_d     = rdy_q;
    tag_d     = tag_q;
    data_d    = data_q;
    rob_d     = rob_q;
    payload_d = payload_q;
    age_d     = age_q;
    count_d   = count_q + CntW'(accept) - CntW'(issue);

    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < NumSrc; s++) begin
        if (valid_q[i] && !rdy_q[i][s] && bus.CDB_Valid_IN &&
            (tag_q[i][s] == bus.CDB_ROB_entry_IN)) begin
          rdy_d[i][s]  = 1'b1;
          data_d[i][s] = bus.CDB_Data_IN;
        end
      end
    end

    if (issue) valid_d = valid_q & ~grant;

    if (accept) begin
      valid_d[free_idx]   = 1'b1;
      rob_d[free_idx]     = bus.Disp_ROB_entry_IN;
      payload_d[free_idx] = bus.Disp_Payload_IN;
      rdy_d[free_idx]     = in_rdy;
      for (int s = 0; s < NumSrc; s++) begin
        tag_d[free_idx][s]  = in_tag[s];
        data_d[free_idx][s] = in_data[s];
      end
      // New entry is younger than everything present; nobody may count it as older.
      age_d[free_idx] = valid_q;
      for (int j = 0; j < DEPTH; j++) age_d[j][free_idx] = 1'b0;
    end

    if (bus.Flush_IN) begin
      valid_d = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdy_q[i]     <= '0;
        rob_q[i]     <= '0;
        payload_q[i] <= '0;
        age_q[i]     <= '0;
        for (int s = 0; s < NumSrc; s++) begin
          tag_q[i][s]  <= '0;
          data_q[i][s] <= '0;
        end
      end
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      rdy_q     <= rdy_d;
      rob_q     <= rob_d;
      payload_q <= payload_d;
      age_q     <= age_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
    end
  end

  // Grant is one-hot or zero, so an AND-OR mux yields zeros when nothing is ready.
  always_comb begin
    bus.Issue_ROB_entry_OUT = '0;
    bus.Issue_OperandA_OUT  = '0;
    bus.Issue_OperandB_OUT  = '0;
    bus.Issue_Payload_OUT   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        bus.Issue_ROB_entry_OUT = bus.Issue_ROB_entry_OUT | rob_q[i];
        bus.Issue_OperandA_OUT  = bus.Issue_OperandA_OUT | data_q[i][SrcA];
        bus.Issue_OperandB_OUT  = bus.Issue_OperandB_OUT | data_q[i][SrcB];
        bus.Issue_Payload_OUT   = bus.Issue_Payload_OUT | payload_q[i];
      end
    end
  end

  assign bus.Issue_Valid_OUT = grant_any;
  assign bus.Disp_Ready_OUT  = disp_ready;
  assign bus.Count_OUT       = count_q;

endmodule

// File: tb/tb_exe_issue_scheduler.sv
// Self-checking bench for exe_issue_scheduler: table-driven single-instruction vectors plus
// hand-written ordering, stall, full, flush and reset sequences, with an issue scoreboard.
module tb_exe_issue_scheduler;
  import exe_issue_scheduler_pkg::*;

  localparam int unsigned Depth = 8;
  localparam int unsigned TagWd = 6;
  localparam int unsigned PlW   = 128;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  exe_issue_scheduler_if #(.DEPTH(Depth), .TAG_W(TagWd), .PAYLOAD_W(PlW)) bus ();

  exe_issue_scheduler #(
    .DEPTH    (Depth),
    .TAG_W    (TagWd),
    .PAYLOAD_W(PlW)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [5:0]   rob;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [127:0] pl;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [5:0]  rob;
    logic        ar;
    logic [5:0]  at;
    logic [31:0] ad;
    logic        br;
    logic [5:0]  bt;
    logic [31:0] bd;
    logic        byp;
    logic [5:0]  ct;
    logic [31:0] cd;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_pl(input logic [5:0] rob);
    logic [31:0] r;
    r = {26'd0, rob};
    return {32'hC0DE_0000 + r, 32'h1234_5678, 32'h9ABC_DEF0 ^ r, r << 3};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Flush_IN           = 1'b0;
    bus.Disp_Valid_IN      = 1'b0;
    bus.Disp_ROB_entry_IN  = '0;
    bus.Disp_Payload_IN    = '0;
    bus.Disp_SrcA_Ready_IN = 1'b0;
    bus.Disp_SrcA_Tag_IN   = '0;
    bus.Disp_SrcA_Data_IN  = '0;
    bus.Disp_SrcB_Ready_IN = 1'b0;
    bus.Disp_SrcB_Tag_IN   = '0;
    bus.Disp_SrcB_Data_IN  = '0;
    bus.CDB_Valid_IN       = 1'b0;
    bus.CDB_ROB_entry_IN   = '0;
    bus.CDB_Data_IN        = '0;
    bus.EXE_Want_Instr_IN  = 1'b0;
  endtask

  task automatic disp(input logic [5:0] rob, input logic ar, input logic [5:0] at,
                      input logic [31:0] ad, input logic br, input logic [5:0] bt,
                      input logic [31:0] bd);
    bus.Disp_Valid_IN      = 1'b1;
    bus.Disp_ROB_entry_IN  = rob;
    bus.Disp_Payload_IN    = mk_pl(rob);
    bus.Disp_SrcA_Ready_IN = ar;
    bus.Disp_SrcA_Tag_IN   = at;
    bus.Disp_SrcA_Data_IN  = ad;
    bus.Disp_SrcB_Ready_IN = br;
    bus.Disp_SrcB_Tag_IN   = bt;
    bus.Disp_SrcB_Data_IN  = bd;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    bus.CDB_Valid_IN     = 1'b1;
    bus.CDB_ROB_entry_IN = tag;
    bus.CDB_Data_IN      = data;
  endtask

  task automatic push(input logic [5:0] rob, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.rob = rob; e.a = a; e.b = b; e.pl = mk_pl(rob);
    sb.push_back(e);
  endtask

  // Scoreboard: every accepted issue must match the next expected instruction.
  always @(negedge CLK) begin
    if (!RESET && bus.Issue_Valid_OUT && bus.EXE_Want_Instr_IN && !bus.Flush_IN) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_issue: got ROB %0d expected no issue", bus.Issue_ROB_entry_OUT);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rob", bus.Issue_ROB_entry_OUT, e.rob);
        check("sb_opa", bus.Issue_OperandA_OUT, e.a);
        check("sb_opb", bus.Issue_OperandB_OUT, e.b);
        check("sb_payload", bus.Issue_Payload_OUT, e.pl);
      end
    end
  end

  initial begin
    logic [5:0] order[3];
    logic       need_wake;

    vecs[0] = '{rob: 6'd5, ar: 1'b1, at: 6'd0, ad: 32'h11, br: 1'b1, bt: 6'd0, bd: 32'h22,
                byp: 1'b0, ct: 6'd0, cd: 32'h0, ea: 32'h11, eb: 32'h22};
    vecs[1] = '{rob: 6'd3, ar: 1'b0, at: 6'd9, ad: 32'h0, br: 1'b1, bt: 6'd0, bd: 32'h33,
                byp: 1'b0, ct: 6'd9, cd: 32'hDEAD, ea: 32'hDEAD, eb: 32'h33};
    vecs[2] = '{rob: 6'd7, ar: 1'b0, at: 6'd12, ad: 32'h0, br: 1'b1, bt: 6'd0, bd: 32'h44,
                byp: 1'b1, ct: 6'd12, cd: 32'h5A, ea: 32'h5A, eb: 32'h44};
    vecs[3] = '{rob: 6'd0, ar: 1'b0, at: 6'd0, ad: 32'h0, br: 1'b0, bt: 6'd0, bd: 32'h0,
                byp: 1'b0, ct: 6'd0, cd: 32'hCAFE, ea: 32'hCAFE, eb: 32'hCAFE};
    vecs[4] = '{rob: 6'd11, ar: 1'b1, at: 6'd9, ad: 32'h77, br: 1'b0, bt: 6'd9, bd: 32'h0,
                byp: 1'b0, ct: 6'd9, cd: 32'h99, ea: 32'h77, eb: 32'h99};

    idle_inputs();
    tick();
    tick();
    RESET = 1'b0;
    check("rst_count", bus.Count_OUT, 0);
    check("rst_ready", bus.Disp_Ready_OUT, 1);
    check("rst_valid", bus.Issue_Valid_OUT, 0);
    check("rst_rob", bus.Issue_ROB_entry_OUT, 0);

    // Table-driven single instructions: dispatch, optional wakeup, issue.
    for (int v = 0; v < 5; v++) begin
      push(vecs[v].rob, vecs[v].ea, vecs[v].eb);
      bus.EXE_Want_Instr_IN = 1'b1;
      disp(vecs[v].rob, vecs[v].ar, vecs[v].at, vecs[v].ad, vecs[v].br, vecs[v].bt,
           vecs[v].bd);
      if (vecs[v].byp) cdb(vecs[v].ct, vecs[v].cd);
      tick();
      bus.Disp_Valid_IN = 1'b0;
      bus.CDB_Valid_IN  = 1'b0;
      check($sformatf("v%0d_count_after_disp", v), bus.Count_OUT, 1);
      need_wake = !vecs[v].byp && !(vecs[v].ar && vecs[v].br);
      if (need_wake) begin
        check($sformatf("v%0d_waiting", v), bus.Issue_Valid_OUT, 0);
        cdb(vecs[v].ct, vecs[v].cd);
        tick();
        bus.CDB_Valid_IN = 1'b0;
      end
      check($sformatf("v%0d_issue_valid", v), bus.Issue_Valid_OUT, 1);
      check($sformatf("v%0d_issue_rob", v), bus.Issue_ROB_entry_OUT, vecs[v].rob);
      tick();
      check($sformatf("v%0d_count_after_issue", v), bus.Count_OUT, 0);
      check($sformatf("v%0d_idle", v), bus.Issue_Valid_OUT, 0);
    end
    bus.EXE_Want_Instr_IN = 1'b0;

    // EXE stall holds the oldest candidate; release issues in dispatch order.
    order[0] = 6'd1; order[1] = 6'd2; order[2] = 6'd4;
    for (int k = 0; k < 3; k++) begin
      push(order[k], 32'h100 + {26'd0, order[k]}, 32'h200 + {26'd0, order[k]});
      disp(order[k], 1'b1, 6'd0, 32'h100 + {26'd0, order[k]}, 1'b1, 6'd0,
           32'h200 + {26'd0, order[k]});
      tick();
    end
    bus.Disp_Valid_IN = 1'b0;
    check("stall_count", bus.Count_OUT, 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_rob_c%0d", k), bus.Issue_ROB_entry_OUT, 1);
      check($sformatf("stall_opa_c%0d", k), bus.Issue_OperandA_OUT, 32'h101);
      tick();
    end
    bus.EXE_Want_Instr_IN = 1'b1;
    tick();
    tick();
    tick();
    bus.EXE_Want_Instr_IN = 1'b0;
    check("stall_drain_count", bus.Count_OUT, 0);
    check("stall_drain_sb", sb.size(), 0);

    // Age beats index: a younger entry reuses slot 0 while an older one sits in slot 1.
    push(6'd20, 32'h2020, 32'h2121);
    disp(6'd20, 1'b1, 6'd0, 32'h2020, 1'b1, 6'd0, 32'h2121);
    tick();
    disp(6'd21, 1'b0, 6'd30, 32'h0, 1'b1, 6'd0, 32'h2222);
    tick();
    bus.Disp_Valid_IN = 1'b0;
    check("age_first", bus.Issue_ROB_entry_OUT, 20);
    bus.EXE_Want_Instr_IN = 1'b1;
    tick();
    bus.EXE_Want_Instr_IN = 1'b0;
    disp(6'd22, 1'b1, 6'd0, 32'h2323, 1'b1, 6'd0, 32'h2424);
    tick();
    bus.Disp_Valid_IN = 1'b0;
    check("age_only_ready", bus.Issue_ROB_entry_OUT, 22);
    cdb(6'd30, 32'h3030);
    tick();
    bus.CDB_Valid_IN = 1'b0;
    check("age_oldest_wins", bus.Issue_ROB_entry_OUT, 21);
    push(6'd21, 32'h3030, 32'h2222);
    push(6'd22, 32'h2323, 32'h2424);
    bus.EXE_Want_Instr_IN = 1'b1;
    tick();
    tick();
    bus.EXE_Want_Instr_IN = 1'b0;
    check("age_drain_count", bus.Count_OUT, 0);

    // Fill all entries with waiting instructions; full station refuses dispatch.
    for (int k = 0; k < 8; k++) begin
      disp(6'd40 + 6'(k), 1'b0, 6'd40 + 6'(k), 32'h0, 1'b1, 6'd0, 32'h500 + k);
      tick();
    end
    bus.Disp_Valid_IN = 1'b0;
    check("full_count", bus.Count_OUT, 8);
    check("full_ready", bus.Disp_Ready_OUT, 0);
    check("full_no_issue", bus.Issue_Valid_OUT, 0);
    disp(6'd60, 1'b1, 6'd0, 32'h60, 1'b1, 6'd0, 32'h60);
    tick();
    bus.Disp_Valid_IN = 1'b0;
    check("full_ignore", bus.Count_OUT, 8);
    cdb(6'd43, 32'h4343);
    tick();
    bus.CDB_Valid_IN = 1'b0;
    check("full_wake_valid", bus.Issue_Valid_OUT, 1);
    check("full_wake_rob", bus.Issue_ROB_entry_OUT, 43);
    push(6'd43, 32'h4343, 32'h503);
    bus.EXE_Want_Instr_IN = 1'b1;
    disp(6'd61, 1'b1, 6'd0, 32'h61, 1'b1, 6'd0, 32'h62);
    tick();
    bus.EXE_Want_Instr_IN = 1'b0;
    check("full_issue_refuses_disp", bus.Count_OUT, 7);
    check("full_ready_again", bus.Disp_Ready_OUT, 1);
    tick();
    bus.Disp_Valid_IN = 1'b0;
    check("full_disp_next_cycle", bus.Count_OUT, 8);
    check("full_new_rob", bus.Issue_ROB_entry_OUT, 61);

    // Flush beats a concurrent dispatch.
    bus.Flush_IN = 1'b1;
    disp(6'd62, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
    tick();
    bus.Flush_IN      = 1'b0;
    bus.Disp_Valid_IN = 1'b0;
    check("flush_count", bus.Count_OUT, 0);
    check("flush_valid", bus.Issue_Valid_OUT, 0);
    check("flush_ready", bus.Disp_Ready_OUT, 1);

    for (int k = 0; k < 5; k++) begin
      disp(6'd50 + 6'(k), 1'b0, 6'd50 + 6'(k), 32'h0, 1'b1, 6'd0, 32'h0);
      tick();
    end
    bus.Disp_Valid_IN = 1'b0;
    check("flush5_count_before", bus.Count_OUT, 5);
    bus.Flush_IN          = 1'b1;
    bus.EXE_Want_Instr_IN = 1'b1;
    disp(6'd63, 1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 32'h4);
    cdb(6'd50, 32'h5050);
    tick();
    bus.Flush_IN          = 1'b0;
    bus.Disp_Valid_IN     = 1'b0;
    bus.CDB_Valid_IN      = 1'b0;
    bus.EXE_Want_Instr_IN = 1'b0;
    check("flush5_count", bus.Count_OUT, 0);
    check("flush5_valid", bus.Issue_Valid_OUT, 0);
    tick();
    check("flush5_still_idle", bus.Issue_Valid_OUT, 0);

    push(6'd33, 32'h8080, 32'h8181);
    bus.EXE_Want_Instr_IN = 1'b1;
    disp(6'd33, 1'b1, 6'd0, 32'h8080, 1'b1, 6'd0, 32'h8181);
    tick();
    bus.Disp_Valid_IN = 1'b0;
    check("post_flush_rob", bus.Issue_ROB_entry_OUT, 33);
    tick();
    bus.EXE_Want_Instr_IN = 1'b0;
    check("post_flush_count", bus.Count_OUT, 0);

    // Asynchronous reset mid-cycle.
    disp(6'd34, 1'b1, 6'd0, 32'h9090, 1'b1, 6'd0, 32'h9191);
    tick();
    disp(6'd35, 1'b1, 6'd0, 32'h9292, 1'b1, 6'd0, 32'h9393);
    tick();
    bus.Disp_Valid_IN = 1'b0;
    check("pre_reset_count", bus.Count_OUT, 2);
    #2;
    RESET = 1'b1;
    #1;
    check("areset_count", bus.Count_OUT, 0);
    check("areset_valid", bus.Issue_Valid_OUT, 0);
    check("areset_ready", bus.Disp_Ready_OUT, 1);
    check("areset_rob", bus.Issue_ROB_entry_OUT, 0);
    check("areset_opa", bus.Issue_OperandA_OUT, 0);
    check("areset_opb", bus.Issue_OperandB_OUT, 0);
    check("areset_payload", bus.Issue_Payload_OUT, 0);
    tick();
    RESET = 1'b0;
    tick();
    check("post_reset_count", bus.Count_OUT, 0);
    check("post_reset_valid", bus.Issue_Valid_OUT, 0);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
